riscv_test_monitor: RTL and testbench
=====================================

Name: riscv_test_monitor

Overview:
- Synthesizable pass/fail monitor for riscv-tests programs running on the RV32I core.
- It snoops the register-file writeback port and keeps shadow copies of the done flag, result and test-number registers.
- Once done is flagged, it waits a settle window, then reports pass, fail or timeout.
- It re-arms on start for back-to-back test programs, and sits beside the core in both simulation and FPGA builds.

Parameters:
- XLEN, 32, register/data width.
- DONE_REG, 26, register index whose non-zero value flags test completion.
- RESULT_REG, 27, register index holding the result.
- TESTNUM_REG, 3, register index holding the current test number.
- PASS_VALUE, 1, value of RESULT_REG that means pass.
- SETTLE_CYCLES, 20, cycles waited after done before the verdict (must be >=1).
- TIMEOUT_CYCLES, 100000, run-cycle limit; 0 disables the timeout.
- CNT_W, 32, width of the cycle counter.

Ports:
- sys_clk_i in 1: system clock.
- rst_i in 1: synchronous, active-high reset.
- start_i in 1: arm the monitor and begin a run (honoured in IDLE only).
- clear_i in 1: abort or clear; return to IDLE.
- wb_en_i in 1: register-file write enable.
- wb_addr_i in 5: register-file write address.
- wb_data_i in XLEN: register-file write data.
- busy_o out 1: high in RUN or SETTLE.
- done_o out 1: verdict valid; held until clear_i, start_i or reset.
- pass_o out 1: result equals PASS_VALUE (valid with done_o).
- fail_o out 1: result differs from PASS_VALUE (valid with done_o).
- timeout_o out 1: timeout fired; held until clear_i, start_i or reset.
- fail_testnum_o out XLEN: TESTNUM_REG shadow latched at the verdict.
- cycle_count_o out CNT_W: cycles spent in RUN plus SETTLE.

Behaviour:
- Reset: FSM goes to IDLE. All outputs and shadows are 0, and both counters are 0.
- Shadow capture: on any edge with wb_en_i=1, wb_addr_i!=0 and wb_addr_i equal to an index parameter, that shadow takes wb_data_i. Writes to x0 are ignored. Capture is active in every state except IDLE.
- FSM states: IDLE, RUN, SETTLE, DONE, TIMEOUT.
- IDLE -> RUN on start_i. This clears the shadows, the settle counter, cycle_count_o, done_o, pass_o, fail_o and timeout_o.
- RUN -> SETTLE when the done shadow is non-zero. Detection is one cycle after the write edge.
- RUN -> TIMEOUT when TIMEOUT_CYCLES!=0 and cycle_count_o==TIMEOUT_CYCLES-1 with the done shadow still zero.
- If done and the timeout limit occur in the same cycle, done wins.
- SETTLE counts SETTLE_CYCLES cycles. On the last one it goes to DONE and registers the verdict:
  - pass_o = (result shadow == PASS_VALUE);
  - fail_o = ~pass_o;
  - fail_testnum_o = testnum shadow.
  Writes that land during SETTLE still update the shadows and count toward the verdict.
- Timeout is not checked in SETTLE.
- Latency: a done write on edge N gives done_o=1 at edge N+2+SETTLE_CYCLES.
- DONE and TIMEOUT are terminal:
  - outputs are held;
  - cycle_count_o is frozen;
  - start_i re-enters RUN with the same clearing as from IDLE.
- clear_i from any state goes to IDLE, clears all outputs and shadows, and wins over a simultaneous start_i.
- rst_i has priority over everything. Reset mid-SETTLE discards the pending verdict.
- cycle_count_o increments in RUN and SETTLE and saturates at all-ones. With TIMEOUT_CYCLES=0 it keeps counting until saturation and no timeout ever fires.
- Output invariants: pass_o and fail_o are never both high; done_o and timeout_o are never both high.

Decomposition:
- Shared package riscv_tb_pkg holds:
  - state enum constants (IDLE/RUN/SETTLE/DONE/TIMEOUT);
  - default register indices (REG_GP=3, REG_DONE=26, REG_RESULT=27);
  - PASS_VALUE default;
  - register address width (5).
- One natural sub-module: wb_shadow_reg. It is parametrised by index and width, and is one instance per snooped register (three instances).

Test Plan:
- Start, then write x27=1 and x26=1 on consecutive edges, SETTLE_CYCLES=4 -> busy_o high, done_o=1 and pass_o=1 exactly 6 edges after the x26 write; fail_o=0.
- Start, write x3=7, x27=0, then x26=1 -> done_o=1, fail_o=1, fail_testnum_o=7; a later clear_i drops all outputs to 0 the next cycle.
- TIMEOUT_CYCLES=50, start, no x26 write -> timeout_o=1 after exactly 50 run cycles, cycle_count_o=50 and frozen, done_o=0.
- Write to x0 with data 1 and address field 0 while x26 shadow is 0, plus writes to x25 and x28 -> no state change. Then x26=1 on the edge where cycle_count_o==TIMEOUT_CYCLES-1 -> SETTLE entered, done wins, timeout_o stays 0.
- After DONE, assert start_i -> RUN with all outputs cleared. In the same cycle assert start_i and clear_i -> IDLE, busy_o=0.
- rst_i asserted during SETTLE (x27=1 already written) -> all outputs 0 next edge, no verdict ever reported, and the monitor requires start_i again.

Source files
------------

// File: rtl/riscv_tb_pkg.sv
// Shared definitions for the riscv-tests pass/fail monitor: FSM states,
// default snooped register indices and the register-address width.
package riscv_tb_pkg;

    localparam int REG_ADDR_W         = 5;
    localparam int REG_GP             = 3;
    localparam int REG_DONE           = 26;
    localparam int REG_RESULT         = 27;
    localparam int DEFAULT_PASS_VALUE = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } mon_state_e;

    function automatic logic is_active(input mon_state_e s);
        return (s == ST_RUN) || (s == ST_SETTLE);
    endfunction

endpackage

// File: rtl/wb_shadow_reg.sv
// Shadow copy of one architectural register, captured by snooping the
// register-file writeback port. Writes to x0 never match.
module wb_shadow_reg
    import riscv_tb_pkg::*;
#(
    parameter int IDX   = REG_DONE,
    parameter int WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  cap_en_i,
    input  logic                  wb_en_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [WIDTH-1:0]      wb_data_i,
    output logic [WIDTH-1:0]      value_o
);

    localparam logic [REG_ADDR_W-1:0] IDX_ADDR = REG_ADDR_W'(IDX);

    logic [WIDTH-1:0] value_d;
    logic [WIDTH-1:0] value_q;
    logic             hit;

    assign hit = cap_en_i && wb_en_i && (wb_addr_i != '0) && (wb_addr_i == IDX_ADDR);

    always_comb begin
        // NOTE: the hold value is assigned first so no path through this block can infer a latch.
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (hit) begin
            value_d = wb_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous here, so rst_i only takes effect on a clock edge.
        if (rst_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail/timeout monitor for riscv-tests programs: snoops the writeback
// port, waits a settle window after the done flag, then latches a verdict.
module riscv_test_monitor
    import riscv_tb_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int DONE_REG       = REG_DONE,
    parameter int RESULT_REG     = REG_RESULT,
    parameter int TESTNUM_REG    = REG_GP,
    parameter int PASS_VALUE     = DEFAULT_PASS_VALUE,
    parameter int SETTLE_CYCLES  = 20,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic                  sys_clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic                  wb_en_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [XLEN-1:0]       wb_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic                  timeout_o,
    output logic [XLEN-1:0]       fail_testnum_o,
    output logic [CNT_W-1:0]      cycle_count_o
);

    localparam int                SETTLE_W     = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic              TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0]  CNT_MAX      = '1;
    localparam logic [XLEN-1:0]   PASS_WORD    = XLEN'(PASS_VALUE);

    mon_state_e           state_d, state_q;
    logic [SETTLE_W-1:0]  settle_d, settle_q;
    logic [CNT_W-1:0]     cycle_d, cycle_q;
    logic                 busy_d, busy_q;
    logic                 done_d, done_q;
    logic                 pass_d, pass_q;
    logic                 fail_d, fail_q;
    logic                 timeout_d, timeout_q;
    logic [XLEN-1:0]      testnum_d, testnum_q;

    logic                 shadow_clr;
    logic                 cap_en;
    logic [XLEN-1:0]      done_shadow;
    logic [XLEN-1:0]      result_shadow;
    logic [XLEN-1:0]      testnum_shadow;

    assign cap_en = (state_q != ST_IDLE);

    wb_shadow_reg #(.IDX(DONE_REG), .WIDTH(XLEN)) u_done_shadow (
        .clk_i     (sys_clk_i),
        .rst_i     (rst_i),
        .clr_i     (shadow_clr),
        .cap_en_i  (cap_en),
        .wb_en_i   (wb_en_i),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .value_o   (done_shadow)
    );

    wb_shadow_reg #(.IDX(RESULT_REG), .WIDTH(XLEN)) u_result_shadow (
        .clk_i     (sys_clk_i),
        .rst_i     (rst_i),
        .clr_i     (shadow_clr),
        .cap_en_i  (cap_en),
        .wb_en_i   (wb_en_i),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .value_o   (result_shadow)
    );

    wb_shadow_reg #(.IDX(TESTNUM_REG), .WIDTH(XLEN)) u_testnum_shadow (
        .clk_i     (sys_clk_i),
        .rst_i     (rst_i),
        .clr_i     (shadow_clr),
        .cap_en_i  (cap_en),
        .wb_en_i   (wb_en_i),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .value_o   (testnum_shadow)
    );

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        cycle_d    = cycle_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        timeout_d  = timeout_q;
        testnum_d  = testnum_q;
        shadow_clr = 1'b0;

        if (clear_i) begin
            state_d    = ST_IDLE;
            settle_d   = '0;
            cycle_d    = '0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            timeout_d  = 1'b0;
            testnum_d  = '0;
            shadow_clr = 1'b1;
        end else begin
            if (is_active(state_q) && (cycle_q != CNT_MAX)) begin
                cycle_d = cycle_q + CNT_W'(1);
            end

            case (state_q)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start_i) begin
                        state_d    = ST_RUN;
                        settle_d   = '0;
                        cycle_d    = '0;
                        done_d     = 1'b0;
                        pass_d     = 1'b0;
                        fail_d     = 1'b0;
                        timeout_d  = 1'b0;
                        testnum_d  = '0;
                        shadow_clr = 1'b1;
                    end
                end
                ST_RUN: begin
                    // The done flag is checked first so it beats a timeout landing on the same cycle.
                    if (done_shadow != '0) begin
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                    end else if (TIMEOUT_EN && (cycle_q == TIMEOUT_LAST)) begin
                        state_d   = ST_TIMEOUT;
                        timeout_d = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        pass_d    = (result_shadow == PASS_WORD);
                        fail_d    = (result_shadow != PASS_WORD);
                        testnum_d = testnum_shadow;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = is_active(state_d);
    end

    always_ff @(posedge sys_clk_i) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (rst_i) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            cycle_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            testnum_q <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            cycle_q   <= cycle_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            testnum_q <= testnum_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign fail_o         = fail_q;
    assign timeout_o      = timeout_q;
    assign fail_testnum_o = testnum_q;
    assign cycle_count_o  = cycle_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: each program's verdict is predicted
// from the writeback trace and checked when the DUT raises done_o or timeout_o.
module tb_riscv_test_monitor;

    localparam int XLEN = 32;
    localparam int S    = 4;
    localparam int T    = 50;
    localparam int LEN  = 58;

    typedef struct {
        int          edge_no;
        bit          done;
        bit          pass;
        bit          fail;
        bit          tmo;
        logic [31:0] testnum;
        logic [31:0] cnt;
    } verdict_t;

    logic        sys_clk   = 1'b0;
    logic        rst_i     = 1'b1;
    logic        start_i   = 1'b0;
    logic        clear_i   = 1'b0;
    logic        wb_en_i   = 1'b0;
    logic [4:0]  wb_addr_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        busy_o, done_o, pass_o, fail_o, timeout_o;
    logic [31:0] fail_testnum_o;
    logic [31:0] cycle_count_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    verdict_t    sb_q[$];
    bit          w_en[1:LEN];
    logic [4:0]  w_addr[1:LEN];
    logic [31:0] w_data[1:LEN];

    riscv_test_monitor #(
        .XLEN(XLEN), .DONE_REG(26), .RESULT_REG(27), .TESTNUM_REG(3), .PASS_VALUE(1),
        .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(32)
    ) dut (
        .sys_clk_i      (sys_clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .clear_i        (clear_i),
        .wb_en_i        (wb_en_i),
        .wb_addr_i      (wb_addr_i),
        .wb_data_i      (wb_data_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .pass_o         (pass_o),
        .fail_o         (fail_o),
        .timeout_o      (timeout_o),
        .fail_testnum_o (fail_testnum_o),
        .cycle_count_o  (cycle_count_o)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_quiet(input string tag, input bit exp_busy);
        check({tag, "_busy"}, busy_o, exp_busy);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_pass"}, pass_o, 0);
        check({tag, "_fail"}, fail_o, 0);
        check({tag, "_timeout"}, timeout_o, 0);
        check({tag, "_testnum"}, fail_testnum_o, 0);
        check({tag, "_count"}, cycle_count_o, 0);
    endtask

    task automatic clear_prog();
        for (int t = 1; t <= LEN; t++) begin
            w_en[t] = 1'b0; w_addr[t] = '0; w_data[t] = '0;
        end
    endtask

    task automatic set_w(input int t, input int a, input logic [31:0] d);
        w_en[t] = 1'b1; w_addr[t] = 5'(a); w_data[t] = d;
    endtask

    // Random writeback trace; the only non-zero x26 write before tw is none.
    task automatic fill_random(input int tw);
        int a;
        for (int t = 1; t <= LEN; t++) begin
            w_en[t] = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0: a = 0;
                1: a = 3;
                2: a = 27;
                3: a = 25;
                4: a = 28;
                default: a = $urandom_range(0, 31);
            endcase
            w_addr[t] = 5'(a);
            case ($urandom_range(0, 3))
                0: w_data[t] = 32'd0;
                1, 2: w_data[t] = 32'd1;
                default: w_data[t] = $urandom;
            endcase
            if (a == 26 && (tw == 0 || t < tw)) w_data[t] = 32'd0;
        end
        if (tw >= 1 && tw <= LEN) set_w(tw, 26, $urandom | 32'd1);
    endtask

    // Reference: first non-zero x26 write decides done vs timeout; the verdict
    // arrives a fixed 2+S edges later and reflects every write before that edge.
    function automatic verdict_t model();
        verdict_t    v;
        int          tw;
        logic [31:0] res;
        logic [31:0] tn;
        tw = 0; res = '0; tn = '0;
        for (int t = 1; t <= LEN; t++)
            if (tw == 0 && w_en[t] && w_addr[t] == 5'd26 && w_data[t] != 0) tw = t;
        if (tw != 0 && tw < T) begin
            v.edge_no = tw + 2 + S;
            for (int t = 1; t < v.edge_no; t++) begin
                if (w_en[t] && w_addr[t] == 5'd27) res = w_data[t];
                if (w_en[t] && w_addr[t] == 5'd3)  tn  = w_data[t];
            end
            v.done = 1; v.pass = (res == 32'd1); v.fail = (res != 32'd1); v.tmo = 0;
            v.testnum = tn; v.cnt = 32'(v.edge_no);
        end else begin
            v.edge_no = T; v.done = 0; v.pass = 0; v.fail = 0; v.tmo = 1;
            v.testnum = '0; v.cnt = 32'(T);
        end
        return v;
    endfunction

    task automatic drive_program(input string tag);
        verdict_t v;
        int       start_edge;
        v = model();
        start_edge = cyc + 1;
        start_i = 1'b1; clear_i = 1'b0; wb_en_i = 1'b0;
        step();
        start_i = 1'b0;
        v.edge_no += start_edge;
        sb_q.push_back(v);
        expect_quiet({tag, "_armed"}, 1'b1);
        for (int t = 1; t <= LEN; t++) begin
            wb_en_i = w_en[t]; wb_addr_i = w_addr[t]; wb_data_i = w_data[t];
            step();
        end
        wb_en_i = 1'b0;
        check({tag, "_held_done"}, done_o, v.done);
        check({tag, "_held_timeout"}, timeout_o, v.tmo);
        check({tag, "_held_pass"}, pass_o, v.pass);
        check({tag, "_held_testnum"}, fail_testnum_o, v.testnum);
        check({tag, "_frozen_count"}, cycle_count_o, v.cnt);
        check({tag, "_busy_after"}, busy_o, 0);
    endtask

    initial begin : monitor
        bit       prev;
        verdict_t e;
        prev = 1'b0;
        forever begin
            @(negedge sys_clk);
            if ((done_o || timeout_o) && !prev) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_verdict: done=%0b timeout=%0b with nothing expected (edge %0d)",
                             done_o, timeout_o, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("verdict_edge", 64'(cyc), 64'(e.edge_no));
                    check("verdict_done", done_o, e.done);
                    check("verdict_pass", pass_o, e.pass);
                    check("verdict_fail", fail_o, e.fail);
                    check("verdict_timeout", timeout_o, e.tmo);
                    check("verdict_testnum", fail_testnum_o, e.testnum);
                    check("verdict_count", cycle_count_o, e.cnt);
                    check("pass_fail_exclusive", pass_o & fail_o, 0);
                    check("done_timeout_exclusive", done_o & timeout_o, 0);
                end
            end
            prev = done_o || timeout_o;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int tw;
        rst_i = 1'b1;
        step(); step();
        expect_quiet("reset", 1'b0);
        rst_i = 1'b0;
        step();
        expect_quiet("post_reset_idle", 1'b0);

        // x27=1 then x26=1: pass exactly 2+S edges after the x26 write.
        clear_prog(); set_w(1, 27, 1); set_w(2, 26, 1);
        drive_program("pass_basic");

        // Failing result with test number 7, then clear.
        clear_prog(); set_w(1, 3, 7); set_w(2, 27, 0); set_w(3, 26, 1);
        drive_program("fail_basic");
        clear_i = 1'b1; step(); clear_i = 1'b0;
        expect_quiet("clear_after_fail", 1'b0);

        // No done write: timeout after T run cycles.
        clear_prog();
        drive_program("timeout");

        // Ignored writes, then done on the last pre-timeout cycle: done wins.
        clear_prog(); set_w(1, 0, 1); set_w(2, 25, 32'hffff_ffff); set_w(3, 28, 1);
        set_w(10, 27, 1); set_w(T - 1, 26, 1);
        drive_program("done_wins");

        // One edge too late: timeout wins.
        clear_prog(); set_w(T, 26, 1);
        drive_program("done_too_late");

        // start and clear together from a terminal state: clear wins.
        start_i = 1'b1; clear_i = 1'b1; step(); start_i = 1'b0; clear_i = 1'b0;
        expect_quiet("start_and_clear", 1'b0);
        repeat (5) step();
        check("idle_stays_idle", busy_o, 0);

        // Reset in SETTLE discards the pending verdict.
        start_i = 1'b1; step(); start_i = 1'b0;
        wb_en_i = 1'b1; wb_addr_i = 5'd27; wb_data_i = 32'd1; step();
        wb_addr_i = 5'd26; step();
        wb_en_i = 1'b0; step(); step();
        check("settle_busy", busy_o, 1);
        rst_i = 1'b1; step(); rst_i = 1'b0;
        expect_quiet("reset_in_settle", 1'b0);
        repeat (20) step();
        expect_quiet("no_restart_without_start", 1'b0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0: tw = 0;
                1: tw = $urandom_range(T - 3, LEN - 1);
                default: tw = $urandom_range(1, T - 4);
            endcase
            fill_random(tw);
            if ($urandom_range(0, 1) == 1) begin
                clear_i = 1'b1; step(); clear_i = 1'b0;
                expect_quiet("random_clear", 1'b0);
            end
            drive_program("random");
        end

        repeat (3) step();
        check("scoreboard_drained", 64'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
